pow_5_res_checker: RTL and testbench

Result-side consumer for the 5th-power pipeline. It records every argument issued into the pipeline and every result that emerges from it, buffering each stream in its own FIFO. A serial multiplier pairs the heads in order, recomputes arg^5 and compares it with the pipeline result. It holds the last checked pair for the board display and keeps pass, error and overflow status.

---
 rtl/pow_5_chk_pkg.sv | 16 +
 rtl/pow_5_chk_fifo.sv | 56 +++++
 rtl/pow_5_res_checker.sv | 162 ++++++++++++++++
 tb/tb_pow_5_res_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pow_5_chk_pkg.sv
// rtl/pow_5_chk_pkg.sv - shared types and constants for the 5th-power result checker
package pow_5_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_CMP  = 2'd2
   } chk_state_e;

   // arg^5 = arg * arg^4, reached from acc = arg by four multiplies
   localparam int N_MUL     = 4;
   localparam int N_W       = $clog2(N_MUL);
   localparam int ERR_CNT_W = 8;
   localparam int RES_CNT_W = 16;

endpackage

// File: rtl/pow_5_chk_fifo.sv
// rtl/pow_5_chk_fifo.sv - synchronous FIFO with push/pop and full/empty flags
module pow_5_chk_fifo #(
   parameter int width = 8,
   parameter int depth = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(depth);

   // One extra pointer bit separates full from empty when the indices match
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [width-1:0] mem_q [depth];
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is only taken when a pop frees the slot this cycle
   always_comb begin
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care while empty so it is not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pow_5_res_checker.sv
// rtl/pow_5_res_checker.sv - pairs pipeline args and results and recomputes arg^5
module pow_5_res_checker
   import pow_5_chk_pkg::*;
#(
   parameter int w     = 8,
   parameter int depth = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 arg_vld,
   input  logic [w-1:0]         arg,
   input  logic                 res_vld,
   input  logic [5*w-1:0]       res,
   output logic [w-1:0]         last_arg,
   output logic [5*w-1:0]       last_res,
   output logic                 chk_done,
   output logic                 chk_ok,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [RES_CNT_W-1:0] res_cnt,
   output logic                 ovf
);

   localparam int RW = 5 * w;

   logic           arg_push, arg_pop, arg_full, arg_empty;
   logic           res_push, res_pop, res_full, res_empty;
   logic [w-1:0]   arg_dout;
   logic [RW-1:0]  res_dout;

   chk_state_e           state_q, state_d;
   logic [w-1:0]         base_q, base_d;
   logic [RW-1:0]        acc_q, acc_d;
   logic [RW-1:0]        r_hold_q, r_hold_d;
   logic [N_W-1:0]       n_q, n_d;
   logic [w-1:0]         last_arg_q, last_arg_d;
   logic [RW-1:0]        last_res_q, last_res_d;
   logic                 chk_done_q, chk_done_d;
   logic                 chk_ok_q, chk_ok_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [RES_CNT_W-1:0] res_cnt_q, res_cnt_d;
   logic                 ovf_q, ovf_d;
   logic [RW-1:0]        base_ext;

   assign arg_push = clk_en & arg_vld;
   assign res_push = clk_en & res_vld;
   assign base_ext = {{(4*w){1'b0}}, base_q};

   pow_5_chk_fifo #(.width(w), .depth(depth)) u_arg_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (arg_push),
      .pop   (arg_pop),
      .din   (arg),
      .dout  (arg_dout),
      .full  (arg_full),
      .empty (arg_empty)
   );

   pow_5_chk_fifo #(.width(RW), .depth(depth)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_push),
      .pop   (res_pop),
      .din   (res),
      .dout  (res_dout),
      .full  (res_full),
      .empty (res_empty)
   );

   // Checker FSM, serial multiplier and status; runs every clock regardless of clk_en
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      acc_d      = acc_q;
      r_hold_d   = r_hold_q;
      n_d        = n_q;
      last_arg_d = last_arg_q;
      last_res_d = last_res_q;
      chk_done_d = 1'b0;
      chk_ok_d   = chk_ok_q;
      err_cnt_d  = err_cnt_q;
      res_cnt_d  = res_cnt_q;
      arg_pop    = 1'b0;
      res_pop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!arg_empty && !res_empty) begin
               arg_pop  = 1'b1;
               res_pop  = 1'b1;
               base_d   = arg_dout;
               acc_d    = {{(4*w){1'b0}}, arg_dout};
               r_hold_d = res_dout;
               n_d      = '0;
               state_d  = ST_MUL;
            end
         end
         ST_MUL: begin
            // arg^5 fits in 5w bits, so truncating the product loses nothing
            acc_d = acc_q * base_ext;
            n_d   = n_q + N_W'(1);
            if (n_q == N_W'(N_MUL - 1)) state_d = ST_CMP;
         end
         ST_CMP: begin
            chk_done_d = 1'b1;
            chk_ok_d   = (acc_q == r_hold_q);
            last_arg_d = base_q;
            last_res_d = r_hold_q;
            res_cnt_d  = res_cnt_q + RES_CNT_W'(1);
            if (acc_q != r_hold_q && err_cnt_q != {ERR_CNT_W{1'b1}})
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A push is lost only when the FIFO is full and not popping this cycle
      ovf_d = ovf_q | (arg_push & arg_full & ~arg_pop)
                    | (res_push & res_full & ~res_pop);
   end

   // State and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         acc_q      <= '0;
         r_hold_q   <= '0;
         n_q        <= '0;
         last_arg_q <= '0;
         last_res_q <= '0;
         chk_done_q <= 1'b0;
         chk_ok_q   <= 1'b0;
         err_cnt_q  <= '0;
         res_cnt_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         acc_q      <= acc_d;
         r_hold_q   <= r_hold_d;
         n_q        <= n_d;
         last_arg_q <= last_arg_d;
         last_res_q <= last_res_d;
         chk_done_q <= chk_done_d;
         chk_ok_q   <= chk_ok_d;
         err_cnt_q  <= err_cnt_d;
         res_cnt_q  <= res_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign last_arg = last_arg_q;
   assign last_res = last_res_q;
   assign chk_done = chk_done_q;
   assign chk_ok   = chk_ok_q;
   assign err_cnt  = err_cnt_q;
   assign res_cnt  = res_cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_pow_5_res_checker.sv
// tb/tb_pow_5_res_checker.sv - directed self-checking bench for pow_5_res_checker
module tb_pow_5_res_checker;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           clk_en = 1'b0;
   logic           arg_vld = 1'b0;
   logic [W-1:0]   arg = '0;
   logic           res_vld = 1'b0;
   logic [5*W-1:0] res = '0;
   logic [W-1:0]   last_arg;
   logic [5*W-1:0] last_res;
   logic           chk_done;
   logic           chk_ok;
   logic [7:0]     err_cnt;
   logic [15:0]    res_cnt;
   logic           ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int ok_cnt = 0;
   int b2b_cnt = 0;
   logic prev_done = 1'b0;

   pow_5_res_checker #(.w(W), .depth(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .arg_vld  (arg_vld),
      .arg      (arg),
      .res_vld  (res_vld),
      .res      (res),
      .last_arg (last_arg),
      .last_res (last_res),
      .chk_done (chk_done),
      .chk_ok   (chk_ok),
      .err_cnt  (err_cnt),
      .res_cnt  (res_cnt),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge and track chk_done pulses
   task automatic tick();
      @(posedge clk);
      #1;
      if (chk_done === 1'b1) begin
         done_cnt++;
         if (chk_ok === 1'b1) ok_cnt++;
         if (prev_done) b2b_cnt++;
      end
      prev_done = (chk_done === 1'b1);
   endtask

   task automatic push(input logic pa, input logic [W-1:0] a, input logic pr, input logic [5*W-1:0] r);
      arg_vld = pa;
      arg     = a;
      res_vld = pr;
      res     = r;
      tick();
      arg_vld = 1'b0;
      res_vld = 1'b0;
   endtask

   // Returns ticks until the next chk_done, or -1 if none within the bound
   task automatic wait_done(input int bound, output int lat);
      int start;
      start = done_cnt;
      lat = 0;
      while (done_cnt == start && lat < bound) begin
         tick();
         lat++;
      end
      if (done_cnt == start) lat = -1;
   endtask

   initial begin
      int lat;
      int d0, o0, timeouts;
      logic [63:0] p;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_last_arg", last_arg, 0);
      check_eq("rst_last_res", last_res, 0);
      check_eq("rst_chk_done", chk_done, 0);
      check_eq("rst_chk_ok", chk_ok, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      check_eq("rst_res_cnt", res_cnt, 0);
      check_eq("rst_ovf", ovf, 0);

      // 3^5 = 243, argument and result five cycles apart
      clk_en = 1'b1;
      push(1'b1, 8'd3, 1'b0, '0);
      repeat (4) tick();
      push(1'b0, '0, 1'b1, 40'd243);
      wait_done(20, lat);
      check_eq("t3_latency", lat, 6);
      check_eq("t3_chk_ok", chk_ok, 1);
      check_eq("t3_res_cnt", res_cnt, 1);
      check_eq("t3_last_res", last_res, 64'hF3);
      check_eq("t3_last_arg", last_arg, 3);
      tick();
      check_eq("t3_pulse_width", chk_done, 0);

      // 255^5 exact, then off by one
      push(1'b1, 8'd255, 1'b1, 40'hFB09F604FF);
      wait_done(20, lat);
      check_eq("t255_latency", lat, 6);
      check_eq("t255_chk_ok", chk_ok, 1);
      check_eq("t255_err_cnt", err_cnt, 0);
      push(1'b1, 8'd255, 1'b1, 40'hFB09F60500);
      wait_done(20, lat);
      check_eq("t255_bad_ok", chk_ok, 0);
      check_eq("t255_bad_err", err_cnt, 1);
      check_eq("t255_bad_last_res", last_res, 64'hFB09F60500);
      check_eq("t255_res_cnt", res_cnt, 3);

      // Edge arguments 0 and 1
      push(1'b1, 8'd0, 1'b1, 40'd0);
      wait_done(20, lat);
      check_eq("t0_chk_ok", chk_ok, 1);
      push(1'b1, 8'd1, 1'b1, 40'd1);
      wait_done(20, lat);
      check_eq("t1_chk_ok", chk_ok, 1);
      check_eq("t1_res_cnt", res_cnt, 5);

      // clk_en low: valid pulses are ignored entirely
      clk_en = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) push(1'b1, 8'(i + 7), 1'b1, 40'd5);
      repeat (12) tick();
      check_eq("en0_no_done", done_cnt - d0, 0);
      check_eq("en0_res_cnt", res_cnt, 5);
      check_eq("en0_err_cnt", err_cnt, 1);
      clk_en = 1'b1;

      // 20 back-to-back correct pairs: pops at push cycles 1,7,13,19 leave 12 accepted
      d0 = done_cnt;
      o0 = ok_cnt;
      for (int i = 0; i < 20; i++) begin
         p = 64'(i + 1);
         p = p * p * p * p * p;
         push(1'b1, 8'(i + 1), 1'b1, p[39:0]);
      end
      repeat (150) tick();
      check_eq("ovf_set", ovf, 1);
      check_eq("ovf_checks", done_cnt - d0, 12);
      check_eq("ovf_all_ok", ok_cnt - o0, 12);
      check_eq("ovf_res_cnt", res_cnt, 17);
      check_eq("ovf_err_cnt", err_cnt, 1);
      check_eq("no_back_to_back", b2b_cnt, 0);

      // 300 mismatches from a clean reset: err_cnt saturates
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("sat_rst_ovf", ovf, 0);
      timeouts = 0;
      for (int i = 0; i < 300; i++) begin
         push(1'b1, 8'd2, 1'b1, 40'd0);
         wait_done(20, lat);
         if (lat < 0) timeouts++;
         if (i == 253) check_eq("sat_err_254", err_cnt, 254);
         if (i == 254) check_eq("sat_err_255", err_cnt, 255);
      end
      check_eq("sat_timeouts", timeouts, 0);
      check_eq("sat_err_cnt", err_cnt, 255);
      check_eq("sat_res_cnt", res_cnt, 300);
      check_eq("sat_chk_ok", chk_ok, 0);

      // Reset during MUL with a second pair still queued
      push(1'b1, 8'd3, 1'b1, 40'd243);
      push(1'b1, 8'd2, 1'b1, 40'd32);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mrst_last_arg", last_arg, 0);
      check_eq("mrst_last_res", last_res, 0);
      check_eq("mrst_chk_done", chk_done, 0);
      check_eq("mrst_chk_ok", chk_ok, 0);
      check_eq("mrst_err_cnt", err_cnt, 0);
      check_eq("mrst_res_cnt", res_cnt, 0);
      check_eq("mrst_ovf", ovf, 0);
      d0 = done_cnt;
      repeat (20) tick();
      check_eq("mrst_no_done", done_cnt - d0, 0);
      push(1'b1, 8'd4, 1'b1, 40'd1024);
      wait_done(20, lat);
      check_eq("mrst_next_latency", lat, 6);
      check_eq("mrst_next_ok", chk_ok, 1);
      check_eq("mrst_next_arg", last_arg, 4);
      check_eq("mrst_next_cnt", res_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
